// File: rtl/seven_seg_counter_mux.sv
// rtl/seven_seg_counter_mux.sv - counter with debounced run/pause and multiplexed seven-segment driver
module seven_seg_counter_mux #(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 2097152,
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CYC = 65536,
    parameter int BCD          = 0,
    parameter int LZ_BLANK     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn,
    input  logic                    up_dn,
    output logic [N_DIGITS-1:0]     dig,
    output logic [6:0]              seg,
    output logic [4*N_DIGITS-1:0]   count,
    output logic                    running
);

    localparam int CW     = 4 * N_DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic              btn_s1, btn_s2;
    logic [DB_W-1:0]   db_cnt;
    logic              db_level, db_level_d;
    logic              press;
    logic [TICK_W-1:0] tick_cnt;
    logic              step;
    logic [CW-1:0]     count_next;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_strobe;
    logic [IDX_W-1:0]  scan_idx;
    logic [3:0]        cur_nib;
    logic              cur_blank;

    // Active-high segment pattern {A,B,C,D,E,F,G} for one hex nibble
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'h7E;
            4'h1:    seg_decode = 7'h30;
            4'h2:    seg_decode = 7'h6D;
            4'h3:    seg_decode = 7'h79;
            4'h4:    seg_decode = 7'h33;
            4'h5:    seg_decode = 7'h5B;
            4'h6:    seg_decode = 7'h5F;
            4'h7:    seg_decode = 7'h70;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h7B;
            4'hA:    seg_decode = 7'h77;
            4'hB:    seg_decode = 7'h1F;
            4'hC:    seg_decode = 7'h4E;
            4'hD:    seg_decode = 7'h3D;
            4'hE:    seg_decode = 7'h4F;
            default: seg_decode = 7'h47;
        endcase
    endfunction

    // Decimal +/-1 with per-digit carry/borrow; out-of-range nibbles are treated as 9
    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic up);
        logic [CW-1:0] r;
        logic          carry;
        logic [3:0]    nib;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            nib = v[4*k +: 4];
            if (carry) begin
                if (up) begin
                    if (nib >= 4'd9) begin
                        r[4*k +: 4] = 4'd0;
                    end else begin
                        r[4*k +: 4] = nib + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0 || nib > 4'd9) begin
                        r[4*k +: 4] = 4'd9;
                    end else begin
                        r[4*k +: 4] = nib - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Stability counter: accept a new level after DEBOUNCE_CYC equal cycles, keep a delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            db_level_d <= db_level;
            if (btn_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= btn_s2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = db_level & ~db_level_d;

    // Run/pause toggles on each accepted press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b1;
        end else if (press) begin
            running <= ~running;
        end
    end

    assign step = running && (tick_cnt == TICK_LAST);

    // Step prescaler advances only while running, so a pause freezes the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (running) begin
            tick_cnt <= step ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // Next count value in the selected number base
    always_comb begin
        count_next = count;
        if (BCD != 0) begin
            count_next = bcd_step(count, up_dn);
        end else if (up_dn) begin
            count_next = count + CW'(1);
        end else begin
            count_next = count - CW'(1);
        end
    end

    // Counter register updates on each step strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (step) begin
            count <= count_next;
        end
    end

    assign scan_strobe = (scan_cnt == SCAN_LAST);

    // Select nibble for the slot about to be lit and decide leading-zero blanking
    always_comb begin
        logic zero_above;
        cur_nib    = 4'h0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (count[4*k +: 4] == 4'h0);
            if (scan_idx == IDX_W'(k)) begin
                cur_nib   = count[4*k +: 4];
                cur_blank = (LZ_BLANK != 0) && (k > 0) && zero_above;
            end
        end
    end

    // Scan prescaler and slot register: scan_idx names the digit shown at the next strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            dig      <= '1;
            seg      <= 7'h7F;
        end else begin
            scan_cnt <= scan_strobe ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_strobe) begin
                dig      <= ~(N_DIGITS'(1) << scan_idx);
                seg      <= cur_blank ? 7'h7F : ~seg_decode(cur_nib);
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_counter_mux.sv
// tb/tb_seven_seg_counter_mux.sv - directed self-checking bench for seven_seg_counter_mux
module tb_seven_seg_counter_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn;
    logic        up_dn;
    logic [3:0]  dig_h, dig_l, dig_b;
    logic [6:0]  seg_h, seg_l, seg_b;
    logic [15:0] cnt_h, cnt_l, cnt_b;
    logic        run_h, run_l, run_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seven_seg_counter_mux #(.N_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(8), .DEBOUNCE_CYC(5), .BCD(0), .LZ_BLANK(0)) u_hex (
        .clk(clk), .rst_n(rst_n), .btn(btn), .up_dn(up_dn),
        .dig(dig_h), .seg(seg_h), .count(cnt_h), .running(run_h)
    );

    seven_seg_counter_mux #(.N_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(8), .DEBOUNCE_CYC(5), .BCD(0), .LZ_BLANK(1)) u_lz (
        .clk(clk), .rst_n(rst_n), .btn(btn), .up_dn(up_dn),
        .dig(dig_l), .seg(seg_l), .count(cnt_l), .running(run_l)
    );

    seven_seg_counter_mux #(.N_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(8), .DEBOUNCE_CYC(5), .BCD(1), .LZ_BLANK(0)) u_bcd (
        .clk(clk), .rst_n(rst_n), .btn(btn), .up_dn(up_dn),
        .dig(dig_b), .seg(seg_b), .count(cnt_b), .running(run_b)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0] d,
                               input logic [6:0] sh, input logic [6:0] sl, input logic [6:0] sb);
        check({tag, "_dig"},     {12'h0, dig_h}, {12'h0, d});
        check({tag, "_dig_bcd"}, {12'h0, dig_b}, {12'h0, d});
        check({tag, "_seg_hex"}, {9'h0, seg_h},  {9'h0, sh});
        check({tag, "_seg_lz"},  {9'h0, seg_l},  {9'h0, sl});
        check({tag, "_seg_bcd"}, {9'h0, seg_b},  {9'h0, sb});
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        up_dn = 1'b1;
        tick(2);
        check("rst_count",   cnt_h, 16'h0000);
        check("rst_running", {15'h0, run_h}, 16'h0001);
        check("rst_dig",     {12'h0, dig_h}, 16'h000F);
        check("rst_seg",     {9'h0, seg_h},  16'h007F);

        // Phase 1: free run from reset, edges counted from release
        rst_n = 1'b1;
        tick(3);
        check("e3_count", cnt_h, 16'h0000);
        tick(1);
        check("e4_count", cnt_h, 16'h0001);
        tick(3);
        check("e7_dig_blank", {12'h0, dig_h}, 16'h000F);
        check("e7_seg_blank", {9'h0, seg_h},  16'h007F);
        tick(1);
        check_frame("e8", 4'b1110, 7'h4F, 7'h4F, 7'h4F);
        check("e8_count", cnt_h, 16'h0002);
        tick(7);
        check("e15_dig_hold", {12'h0, dig_h}, 16'h000E);
        tick(1);
        check_frame("e16", 4'b1101, 7'h01, 7'h7F, 7'h01);
        tick(8);
        check("e24_dig", {12'h0, dig_h}, 16'h000B);
        tick(8);
        check("e32_dig", {12'h0, dig_h}, 16'h0007);
        tick(8);
        check_frame("e40", 4'b1110, 7'h04, 7'h04, 7'h04);
        tick(8);
        check_frame("e48", 4'b1101, 7'h01, 7'h7F, 7'h4F);
        check("e48_count_hex", cnt_h, 16'h000C);
        check("e48_count_bcd", cnt_b, 16'h0012);

        // Press coincides with the step strobe at edge 56
        btn = 1'b1;
        tick(7);
        check("e55_running", {15'h0, run_h}, 16'h0001);
        check("e55_count",   cnt_h, 16'h000D);
        tick(1);
        check("e56_running",     {15'h0, run_h}, 16'h0000);
        check("e56_count_hex",   cnt_h, 16'h000E);
        check("e56_count_bcd",   cnt_b, 16'h0014);
        tick(4);
        btn = 1'b0;
        tick(20);
        check("e80_paused_run",   {15'h0, run_h}, 16'h0000);
        check("e80_paused_count", cnt_h, 16'h000E);

        // Single-cycle bounces must be rejected
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            tick(1);
            btn = 1'b0;
            tick(2);
        end
        tick(10);
        check("e99_bounce_run",   {15'h0, run_h}, 16'h0000);
        check("e99_bounce_count", cnt_h, 16'h000E);

        // Second press resumes from the held prescaler phase
        btn = 1'b1;
        tick(7);
        check("e106_running", {15'h0, run_h}, 16'h0000);
        tick(1);
        check("e107_running", {15'h0, run_h}, 16'h0001);
        tick(3);
        check("e110_count", cnt_h, 16'h000E);
        tick(1);
        check("e111_count_hex", cnt_h, 16'h000F);
        check("e111_count_bcd", cnt_b, 16'h0015);
        tick(3);
        rst_n = 1'b0;
        btn   = 1'b0;
        #1;
        check("midrst_dig",   {12'h0, dig_h}, 16'h000F);
        check("midrst_seg",   {9'h0, seg_h},  16'h007F);
        check("midrst_count", cnt_h, 16'h0000);

        // Phase 2: run to 0x40 and pause there to inspect blanking
        tick(2);
        rst_n = 1'b1;
        tick(248);
        btn = 1'b1;
        tick(7);
        check("e255_count_hex", cnt_h, 16'h003F);
        check("e255_count_bcd", cnt_b, 16'h0063);
        tick(1);
        check("e256_running",   {15'h0, run_h}, 16'h0000);
        check("e256_count_hex", cnt_h, 16'h0040);
        check("e256_count_lz",  cnt_l, 16'h0040);
        check("e256_count_bcd", cnt_b, 16'h0064);
        tick(8);
        check_frame("lz_d0", 4'b1110, 7'h01, 7'h01, 7'h4C);
        tick(8);
        check_frame("lz_d1", 4'b1101, 7'h4C, 7'h4C, 7'h20);
        tick(8);
        check_frame("lz_d2", 4'b1011, 7'h01, 7'h7F, 7'h01);
        tick(8);
        check_frame("lz_d3", 4'b0111, 7'h01, 7'h7F, 7'h01);
        rst_n = 1'b0;
        btn   = 1'b0;
        #1;
        check("pausedrst_running", {15'h0, run_h}, 16'h0001);
        check("pausedrst_count",   cnt_h, 16'h0000);
        check("pausedrst_dig",     {12'h0, dig_h}, 16'h000F);

        // Phase 3: wrap in both directions, then BCD decade carry/borrow
        tick(2);
        up_dn = 1'b0;
        rst_n = 1'b1;
        tick(4);
        check("wrap_dn_hex", cnt_h, 16'hFFFF);
        check("wrap_dn_bcd", cnt_b, 16'h9999);
        up_dn = 1'b1;
        tick(4);
        check("wrap_up_hex", cnt_h, 16'h0000);
        check("wrap_up_bcd", cnt_b, 16'h0000);
        tick(399);
        check("e407_count_hex", cnt_h, 16'h0063);
        check("e407_count_bcd", cnt_b, 16'h0099);
        tick(1);
        check("e408_count_hex", cnt_h, 16'h0064);
        check("e408_count_bcd", cnt_b, 16'h0100);
        up_dn = 1'b0;
        tick(4);
        check("e412_count_hex", cnt_h, 16'h0063);
        check("e412_count_bcd", cnt_b, 16'h0099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
